// File: rtl/wb_commit_stage_if.sv
// ============================================================================
// Module  : wb_commit_stage_if
// Brief   : MEM->WB bundle, regfile/CSR results and store-queue drain bus.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_commit_stage_if #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                      pre_valid_i;
    logic                      now_allowin_o;
    logic [LANES-1:0]          lane_valid_i;
    logic [LANES*32-1:0]       lane_pc_i;
    logic [LANES-1:0]          lane_we_i;
    logic [LANES*5-1:0]        lane_waddr_i;
    logic [LANES*32-1:0]       lane_wdata_i;
    logic [LANES-1:0]          lane_excep_i;
    logic [LANES*6-1:0]        lane_ecode_i;
    logic [LANES-1:0]          lane_st_i;
    logic [LANES*ADDR_W-1:0]   lane_st_addr_i;
    logic [LANES*DATA_W-1:0]   lane_st_data_i;
    logic [LANES*DATA_W/8-1:0] lane_st_strb_i;
    logic [LANES-1:0]          rf_we_o;
    logic [LANES*5-1:0]        rf_waddr_o;
    logic [LANES*32-1:0]       rf_wdata_o;
    logic                      wb_flush_o;
    logic                      excep_en_o;
    logic [5:0]                excep_ecode_o;
    logic [31:0]               excep_pc_o;
    logic                      sq_valid_o;
    logic                      sq_ready_i;
    logic [ADDR_W-1:0]         sq_addr_o;
    logic [DATA_W-1:0]         sq_data_o;
    logic [DATA_W/8-1:0]       sq_strb_o;
    logic [$clog2(DEPTH+1)-1:0] sq_count_o;
`ifdef WB_COMMIT_DIFFTEST_EN
    logic [LANES-1:0]          diff_commit_o;
    logic [63:0]               diff_retired_o;
`endif

    modport slave (
        input  pre_valid_i, lane_valid_i, lane_pc_i, lane_we_i, lane_waddr_i, lane_wdata_i,
               lane_excep_i, lane_ecode_i, lane_st_i, lane_st_addr_i, lane_st_data_i,
               lane_st_strb_i, sq_ready_i,
        output now_allowin_o, rf_we_o, rf_waddr_o, rf_wdata_o, wb_flush_o, excep_en_o,
               excep_ecode_o, excep_pc_o, sq_valid_o, sq_addr_o, sq_data_o, sq_strb_o,
               sq_count_o
`ifdef WB_COMMIT_DIFFTEST_EN
        , diff_commit_o, diff_retired_o
`endif
    );

    modport master (
        output pre_valid_i, lane_valid_i, lane_pc_i, lane_we_i, lane_waddr_i, lane_wdata_i,
               lane_excep_i, lane_ecode_i, lane_st_i, lane_st_addr_i, lane_st_data_i,
               lane_st_strb_i, sq_ready_i,
        input  now_allowin_o, rf_we_o, rf_waddr_o, rf_wdata_o, wb_flush_o, excep_en_o,
               excep_ecode_o, excep_pc_o, sq_valid_o, sq_addr_o, sq_data_o, sq_strb_o,
               sq_count_o
`ifdef WB_COMMIT_DIFFTEST_EN
        , diff_commit_o, diff_retired_o
`endif
    );
endinterface

`default_nettype wire

// File: rtl/wb_commit_stage.sv
// ============================================================================
// Module  : wb_commit_stage
// Brief   : Multi-lane writeback/commit with precise exceptions and a committed
//           store queue. Optional WB_COMMIT_DIFFTEST_EN adds commit trace ports.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_commit_stage #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    wb_commit_stage_if.slave    bus
);
    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_LCNT_W = $clog2(LANES + 1);

    logic                        r_valid;
    logic [LANES-1:0]            r_lane_valid;
    logic [LANES*32-1:0]         r_pc;
    logic [LANES-1:0]            r_we;
    logic [LANES*5-1:0]          r_waddr;
    logic [LANES*32-1:0]         r_wdata;
    logic [LANES-1:0]            r_excep;
    logic [LANES*6-1:0]          r_ecode;
    logic [LANES-1:0]            r_st;
    logic [LANES*ADDR_W-1:0]     r_st_addr;
    logic [LANES*DATA_W-1:0]     r_st_data;
    logic [LANES*c_STRB_W-1:0]   r_st_strb;

    logic [ADDR_W-1:0]           r_sq_addr [DEPTH];
    logic [DATA_W-1:0]           r_sq_data [DEPTH];
    logic [c_STRB_W-1:0]         r_sq_strb [DEPTH];
    logic [c_PTR_W-1:0]          r_head;
    logic [c_PTR_W-1:0]          r_tail;
    logic [c_CNT_W-1:0]          r_count;

    logic [LANES-1:0]            w_commit;
    logic                        w_blocked;
    logic                        w_excep_hit;
    logic [5:0]                  w_ecode;
    logic [31:0]                 w_pc;
    logic [c_LCNT_W-1:0]         w_st_cnt;
    logic [c_LCNT_W-1:0]         w_off [LANES];
    logic [c_LCNT_W-1:0]         w_push_n;
    logic [LANES-1:0]            w_push;
    logic                        w_ready_go;
    logic                        w_go;
    logic                        w_allowin;
    logic                        w_load;
    logic                        w_pop;

    // Oldest excepting lane blocks itself and every younger lane.
    always_comb begin
        w_commit    = '0;
        w_blocked   = 1'b0;
        w_excep_hit = 1'b0;
        w_ecode     = 6'd0;
        w_pc        = 32'd0;
        w_st_cnt    = '0;
        for (int i = 0; i < LANES; i++) begin
            w_off[i] = w_st_cnt;
            if (r_valid && r_lane_valid[i] && !w_blocked) begin
                if (r_excep[i]) begin
                    w_blocked   = 1'b1;
                    w_excep_hit = 1'b1;
                    w_ecode     = r_ecode[i*6 +: 6];
                    w_pc        = r_pc[i*32 +: 32];
                end else begin
                    w_commit[i] = 1'b1;
                    if (r_st[i]) begin
                        w_st_cnt = w_st_cnt + c_LCNT_W'(1);
                    end
                end
            end
        end
    end

    // Free space is judged against the current occupancy only; a same-cycle pop is not credited.
    assign w_ready_go = (32'(w_st_cnt) <= (32'(DEPTH) - 32'(r_count)));
    assign w_go       = r_valid & w_ready_go;
    assign w_allowin  = ~r_valid | w_ready_go;
    assign w_load     = bus.pre_valid_i & w_allowin;
    assign w_push     = w_commit & r_st & {LANES{w_go}};
    assign w_push_n   = w_go ? w_st_cnt : '0;
    assign w_pop      = (r_count != '0) & bus.sq_ready_i;

    assign bus.now_allowin_o = w_allowin;
    assign bus.rf_we_o       = r_we & w_commit & {LANES{w_go}};
    assign bus.rf_waddr_o    = r_waddr;
    assign bus.rf_wdata_o    = r_wdata;
    assign bus.wb_flush_o    = w_go & w_excep_hit;
    assign bus.excep_en_o    = w_go & w_excep_hit;
    assign bus.excep_ecode_o = w_go ? w_ecode : 6'd0;
    assign bus.excep_pc_o    = w_go ? w_pc : 32'd0;
    assign bus.sq_valid_o    = (r_count != '0);
    assign bus.sq_addr_o     = (r_count != '0) ? r_sq_addr[r_head] : '0;
    assign bus.sq_data_o     = (r_count != '0) ? r_sq_data[r_head] : '0;
    assign bus.sq_strb_o     = (r_count != '0) ? r_sq_strb[r_head] : '0;
    assign bus.sq_count_o    = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_lane_valid <= '0;
            r_pc         <= '0;
            r_we         <= '0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_excep      <= '0;
            r_ecode      <= '0;
            r_st         <= '0;
            r_st_addr    <= '0;
            r_st_data    <= '0;
            r_st_strb    <= '0;
        end else if (w_load) begin
            r_valid      <= 1'b1;
            r_lane_valid <= bus.lane_valid_i;
            r_pc         <= bus.lane_pc_i;
            r_we         <= bus.lane_we_i;
            r_waddr      <= bus.lane_waddr_i;
            r_wdata      <= bus.lane_wdata_i;
            r_excep      <= bus.lane_excep_i;
            r_ecode      <= bus.lane_ecode_i;
            r_st         <= bus.lane_st_i;
            r_st_addr    <= bus.lane_st_addr_i;
            r_st_data    <= bus.lane_st_data_i;
            r_st_strb    <= bus.lane_st_strb_i;
        end else if (w_go) begin
            r_valid      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= c_PTR_W'((32'(r_head) + 32'd1) % DEPTH);
            end
            r_tail  <= c_PTR_W'((32'(r_tail) + 32'(w_push_n)) % DEPTH);
            r_count <= r_count + c_CNT_W'(w_push_n) - c_CNT_W'(w_pop);
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_push[i]) begin
                r_sq_addr[c_PTR_W'((32'(r_tail) + 32'(w_off[i])) % DEPTH)] <= r_st_addr[i*ADDR_W +: ADDR_W];
                r_sq_data[c_PTR_W'((32'(r_tail) + 32'(w_off[i])) % DEPTH)] <= r_st_data[i*DATA_W +: DATA_W];
                r_sq_strb[c_PTR_W'((32'(r_tail) + 32'(w_off[i])) % DEPTH)] <= r_st_strb[i*c_STRB_W +: c_STRB_W];
            end
        end
    end

`ifdef WB_COMMIT_DIFFTEST_EN
    logic [LANES-1:0]    w_diff_commit;
    logic [c_LCNT_W-1:0] w_commit_n;
    logic [63:0]         r_retired;

    assign w_diff_commit = w_commit & {LANES{w_go}};

    always_comb begin
        w_commit_n = '0;
        for (int i = 0; i < LANES; i++) begin
            w_commit_n = w_commit_n + c_LCNT_W'(w_diff_commit[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= 64'd0;
        end else begin
            r_retired <= r_retired + 64'(w_commit_n);
        end
    end

    assign bus.diff_commit_o  = w_diff_commit;
    assign bus.diff_retired_o = r_retired;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
// ============================================================================
// Module  : tb_wb_commit_stage
// Brief   : Directed and random stimulus against a queue-based commit model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_commit_stage;
    localparam int LANES  = 2;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic        lv;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ex;
        logic [5:0]  ec;
        logic        st;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [3:0]  ss;
    } lane_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } st_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_commit_stage_if #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wb_commit_stage #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lane_t           in_l [LANES];
    logic            in_pre_valid;
    logic            in_sq_ready;

    lane_t           m_l [LANES];
    bit              m_hold;
    st_t             q [$];
    longint unsigned m_retired;
    int              m_k;
    bit              m_commit [LANES];
    bit              m_ready;
    bit              m_go;
    bit              m_loaded;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.pre_valid_i = in_pre_valid;
        bus.sq_ready_i  = in_sq_ready;
        for (int i = 0; i < LANES; i++) begin
            bus.lane_valid_i[i]          = in_l[i].lv;
            bus.lane_pc_i[i*32 +: 32]    = in_l[i].pc;
            bus.lane_we_i[i]             = in_l[i].we;
            bus.lane_waddr_i[i*5 +: 5]   = in_l[i].waddr;
            bus.lane_wdata_i[i*32 +: 32] = in_l[i].wdata;
            bus.lane_excep_i[i]          = in_l[i].ex;
            bus.lane_ecode_i[i*6 +: 6]   = in_l[i].ec;
            bus.lane_st_i[i]             = in_l[i].st;
            bus.lane_st_addr_i[i*32 +: 32] = in_l[i].sa;
            bus.lane_st_data_i[i*32 +: 32] = in_l[i].sd;
            bus.lane_st_strb_i[i*4 +: 4]   = in_l[i].ss;
        end
    endtask

    // Architectural view: first excepting valid lane retires nothing at or after it.
    task automatic model_eval();
        int nst;
        m_k = -1;
        nst = 0;
        for (int i = 0; i < LANES; i++) m_commit[i] = 0;
        if (m_hold) begin
            for (int i = 0; i < LANES; i++) begin
                if (m_k < 0 && m_l[i].lv && m_l[i].ex) m_k = i;
            end
            for (int i = 0; i < LANES; i++) begin
                m_commit[i] = m_l[i].lv && !m_l[i].ex && (m_k < 0 || i < m_k);
                if (m_commit[i] && m_l[i].st) nst++;
            end
        end
        m_ready = (nst <= DEPTH - q.size());
        m_go    = m_hold && m_ready;
    endtask

    task automatic check_all();
        logic [LANES-1:0]    e_we;
        logic [LANES*5-1:0]  e_wa;
        logic [LANES*32-1:0] e_wd;
        bit                  e_fl;
        model_eval();
        for (int i = 0; i < LANES; i++) begin
            e_we[i]           = m_go && m_commit[i] && m_l[i].we;
            e_wa[i*5 +: 5]    = m_l[i].waddr;
            e_wd[i*32 +: 32]  = m_l[i].wdata;
        end
        e_fl = m_go && (m_k >= 0);
        chk("rf_we",    64'(bus.rf_we_o),       64'(e_we));
        chk("rf_waddr", 64'(bus.rf_waddr_o),    64'(e_wa));
        chk("rf_wdata", 64'(bus.rf_wdata_o),    64'(e_wd));
        chk("flush",    64'(bus.wb_flush_o),    64'(e_fl));
        chk("excep_en", 64'(bus.excep_en_o),    64'(e_fl));
        chk("ecode",    64'(bus.excep_ecode_o), e_fl ? 64'(m_l[m_k].ec) : 64'd0);
        chk("excep_pc", 64'(bus.excep_pc_o),    e_fl ? 64'(m_l[m_k].pc) : 64'd0);
        chk("allowin",  64'(bus.now_allowin_o), 64'(!m_hold || m_ready));
        chk("sq_valid", 64'(bus.sq_valid_o),    64'(q.size() != 0));
        chk("sq_count", 64'(bus.sq_count_o),    64'(q.size()));
        chk("count_le_depth", 64'(bus.sq_count_o <= DEPTH), 64'd1);
        if (q.size() != 0) begin
            chk("sq_addr", 64'(bus.sq_addr_o), 64'(q[0].a));
            chk("sq_data", 64'(bus.sq_data_o), 64'(q[0].d));
            chk("sq_strb", 64'(bus.sq_strb_o), 64'(q[0].s));
        end
`ifdef WB_COMMIT_DIFFTEST_EN
        chk("diff_retired", bus.diff_retired_o, 64'(m_retired));
`endif
    endtask

    task automatic step();
        bit ld;
        bit pop;
        drive();
        check_all();
        ld  = in_pre_valid && (!m_hold || m_ready);
        pop = (q.size() != 0) && in_sq_ready;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (m_go) begin
            for (int i = 0; i < LANES; i++) begin
                if (m_commit[i]) begin
                    m_retired++;
                    if (m_l[i].st) q.push_back('{a: m_l[i].sa, d: m_l[i].sd, s: m_l[i].ss});
                end
            end
        end
        if (ld) begin
            m_hold = 1;
            for (int i = 0; i < LANES; i++) m_l[i] = in_l[i];
        end else if (m_go) begin
            m_hold = 0;
        end
        m_loaded = ld;
        #1;
    endtask

    task automatic model_reset();
        m_hold    = 0;
        m_retired = 0;
        q.delete();
        for (int i = 0; i < LANES; i++) m_l[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        drive();
        check_all();
        chk("reset_allowin", 64'(bus.now_allowin_o), 64'd1);
        chk("reset_count",   64'(bus.sq_count_o),    64'd0);
        chk("reset_flush",   64'(bus.wb_flush_o),    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic lane_t rand_lane();
        lane_t l;
        l.lv    = ($urandom_range(0, 7) != 0);
        l.pc    = $urandom;
        l.we    = $urandom_range(0, 1);
        l.waddr = 5'($urandom);
        l.wdata = $urandom;
        l.ex    = l.lv && ($urandom_range(0, 7) == 0);
        l.ec    = 6'($urandom);
        l.st    = $urandom_range(0, 1);
        l.sa    = $urandom;
        l.sd    = $urandom;
        l.ss    = 4'($urandom);
        return l;
    endfunction

    function automatic lane_t plain_lane(input int n, input bit st);
        lane_t l;
        l       = '0;
        l.lv    = 1;
        l.pc    = 32'h1c000000 + 32'(n * 4);
        l.we    = !st;
        l.waddr = 5'(n + 1);
        l.wdata = 32'hA000_0000 + 32'(n);
        l.st    = st;
        l.sa    = 32'h8000_0000 + 32'(n * 4);
        l.sd    = 32'h5000_0000 + 32'(n);
        l.ss    = 4'hF;
        return l;
    endfunction

    initial begin
        int waited;
        int accepted;
        int bound;
        rst          = 1'b1;
        in_pre_valid = 1'b0;
        in_sq_ready  = 1'b0;
        for (int i = 0; i < LANES; i++) in_l[i] = '0;
        model_reset();
        drive();
        @(posedge clk);
        #1;
        do_reset();

        // Dual ALU lanes writing x3 and x4.
        in_l[0] = plain_lane(2, 0);
        in_l[1] = plain_lane(3, 0);
        in_pre_valid = 1'b1;
        step();
        in_pre_valid = 1'b0;
        chk("dual_we",   64'(bus.rf_we_o),    64'd3);
        chk("dual_wa",   64'(bus.rf_waddr_o), 64'h83);
        chk("dual_nofl", 64'(bus.wb_flush_o), 64'd0);
        step();

        // Oldest lane excepts; the younger store must not reach the queue.
        in_l[0]    = plain_lane(4, 0);
        in_l[0].ex = 1; in_l[0].ec = 6'h0B; in_l[0].pc = 32'h1c000010;
        in_l[1]    = plain_lane(5, 1);
        in_pre_valid = 1'b1;
        step();
        in_pre_valid = 1'b0;
        chk("old_pc",    64'(bus.excep_pc_o),    64'h1c000010);
        chk("old_ecode", 64'(bus.excep_ecode_o), 64'h0B);
        chk("old_flush", 64'(bus.wb_flush_o),    64'd1);
        chk("old_we",    64'(bus.rf_we_o),       64'd0);
        step();
        chk("old_nopush", 64'(bus.sq_count_o), 64'd0);
        chk("old_noflush_after", 64'(bus.wb_flush_o), 64'd0);

        // Younger lane excepts; the older lane still retires.
        in_l[0]    = plain_lane(6, 0);
        in_l[1]    = plain_lane(7, 0);
        in_l[1].ex = 1; in_l[1].ec = 6'h09; in_l[1].pc = 32'h1c000024;
        in_pre_valid = 1'b1;
        step();
        in_pre_valid = 1'b0;
        chk("young_we",    64'(bus.rf_we_o),       64'd1);
        chk("young_pc",    64'(bus.excep_pc_o),    64'h1c000024);
        chk("young_ecode", 64'(bus.excep_ecode_o), 64'h09);
        step();

        // Fill the queue with four 2-store bundles, then offer a fifth.
        in_sq_ready  = 1'b0;
        in_pre_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            in_l[0] = plain_lane(10 + 2 * b, 1);
            in_l[1] = plain_lane(11 + 2 * b, 1);
            step();
        end
        in_pre_valid = 1'b0;
        step();
        chk("full_count",   64'(bus.sq_count_o),    64'd8);
        chk("full_allowin", 64'(bus.now_allowin_o), 64'd0);
        step();
        chk("full_hold_we", 64'(bus.sq_count_o),    64'd8);
        in_sq_ready = 1'b1;
        waited = 0;
        while (!bus.now_allowin_o && waited < 10) begin
            step();
            waited++;
        end
        chk("full_unstall_cycles", 64'(waited), 64'd2);
        for (int c = 0; c < 12; c++) step();

        // Twenty stores with the cache toggling ready every cycle.
        accepted = 0;
        bound    = 0;
        in_l[0]  = plain_lane(40, 1);
        in_l[1]  = plain_lane(41, 1);
        in_pre_valid = 1'b1;
        while (accepted < 10 && bound < 200) begin
            in_sq_ready = bound[0];
            step();
            bound++;
            if (m_loaded) begin
                accepted++;
                in_l[0] = plain_lane(40 + 2 * accepted, 1);
                in_l[1] = plain_lane(41 + 2 * accepted, 1);
            end
        end
        chk("wrap_all_accepted", 64'(accepted), 64'd10);
        in_pre_valid = 1'b0;
        in_sq_ready  = 1'b1;
        for (int c = 0; c < 14; c++) step();
        chk("wrap_drained", 64'(bus.sq_count_o), 64'd0);

        // Random traffic with a reset in the middle.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < LANES; i++) in_l[i] = rand_lane();
            in_pre_valid = ($urandom_range(0, 3) != 0);
            in_sq_ready  = ($urandom_range(0, 2) == 0);
            if (c == 300) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
